// File: rtl/param_register_file_pkg.sv
// Shared types and default sizing for the parameterised register file.
package param_register_file_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_NUM_READ   = 2;
    localparam int unsigned DEF_ZERO_REG   = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage : param_register_file_pkg

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: owns state, sweep pointer, Busy and the dropped-write pulse.
module regfile_clear_fsm
    import param_register_file_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  Clear,
    input  logic                  WriteEnable,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  write_dropped,
    output logic                  write_accept_c
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    state_e                state, state_n;
    logic [ADDR_WIDTH-1:0] ptr_n;
    logic                  dropped_n;

    // Reset lands in CLEAR so storage is swept before first use.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state         <= ST_CLEAR;
            ptr           <= '0;
            write_dropped <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            write_dropped <= dropped_n;
        end
    end

    always_comb begin
        state_n        = state;
        ptr_n          = ptr;
        write_accept_c = 1'b0;
        dropped_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Clear) begin
                    state_n = ST_CLEAR;
                    ptr_n   = '0;
                end else begin
                    write_accept_c = WriteEnable;
                end
            end
            ST_CLEAR: begin
                // Clear requests are ignored here; the sweep never restarts.
                ptr_n = ptr + ADDR_WIDTH'(1);
                if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_CLEAR;
                ptr_n   = '0;
            end
        endcase
        dropped_n = WriteEnable & ~write_accept_c;
    end

    assign busy = (state == ST_CLEAR);

endmodule : regfile_clear_fsm

// File: rtl/param_register_file.sv
// Multi-read-port register file with write-through bypass and a sweeping clear.
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_READ   = DEF_NUM_READ,
    parameter int unsigned ZERO_REG   = DEF_ZERO_REG
) (
    input  logic                           Clock,
    input  logic                           nReset,
    input  logic                           Clear,
    output logic                           Busy,
    input  logic                           WriteEnable,
    input  logic [ADDR_WIDTH-1:0]          WriteAddress,
    input  logic [DATA_WIDTH-1:0]          WriteData,
    output logic                           WriteDropped,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadAddress,
    output logic [NUM_READ*DATA_WIDTH-1:0] ReadData
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] ptr;
    logic                  write_accept_c;
    logic                  zero_target_c;
    logic [DATA_WIDTH-1:0] regs [DEPTH];

    regfile_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .Clock          (Clock),
        .nReset         (nReset),
        .Clear          (Clear),
        .WriteEnable    (WriteEnable),
        .busy           (Busy),
        .ptr            (ptr),
        .write_dropped  (WriteDropped),
        .write_accept_c (write_accept_c)
    );

    assign zero_target_c = (ZERO_REG != 0) && (WriteAddress == '0);

    // Storage has no reset; the sweep is the only way it gets cleared.
    always_ff @(posedge Clock) begin
        if (Busy) begin
            regs[ptr] <= '0;
        end else if (write_accept_c && !zero_target_c) begin
            regs[WriteAddress] <= WriteData;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr_c;
        logic [DATA_WIDTH-1:0] data_c;

        assign addr_c = ReadAddress[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            data_c = '0;
            if (Busy) begin
                data_c = '0;
            end else if ((ZERO_REG != 0) && (addr_c == '0)) begin
                data_c = '0;
            end else if (write_accept_c && (addr_c == WriteAddress)) begin
                data_c = WriteData;
            end else begin
                data_c = regs[addr_c];
            end
        end

        assign ReadData[i*DATA_WIDTH +: DATA_WIDTH] = data_c;
    end

endmodule : param_register_file

// File: tb/tb_param_register_file.sv
// Randomised plus directed check of two register file instances against an array model.
module tb_param_register_file;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 6;
    localparam int unsigned NR    = 2;
    localparam int unsigned DEPTH = 64;

    logic             Clock = 1'b0;
    logic             nReset;
    logic             Clear;
    logic             WriteEnable;
    logic [AW-1:0]    WriteAddress;
    logic [DW-1:0]    WriteData;
    logic [NR*AW-1:0] ReadAddress;

    logic             busy0, drop0, busy1, drop1;
    logic [NR*DW-1:0] rd0, rd1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [DW-1:0] model [DEPTH];
    int            busy_left;
    logic          drop_exp;
    logic          last_busy;

    always #5 Clock = ~Clock;

    param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(0)) dut (
        .Clock(Clock), .nReset(nReset), .Clear(Clear), .Busy(busy0),
        .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData),
        .WriteDropped(drop0), .ReadAddress(ReadAddress), .ReadData(rd0)
    );

    param_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1)) dut_z (
        .Clock(Clock), .nReset(nReset), .Clear(Clear), .Busy(busy1),
        .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData),
        .WriteDropped(drop1), .ReadAddress(ReadAddress), .ReadData(rd1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input bit zr, input logic [AW-1:0] a);
        if (busy_left > 0) return '0;
        if (zr && a == '0) return '0;
        if (WriteEnable && !Clear && a == WriteAddress) return WriteData;
        return model[a];
    endfunction

    task automatic model_sweep_start();
        busy_left = DEPTH;
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
    endtask

    // One clock: drive, check mid-cycle, advance model at the edge.
    task automatic cycle(input bit clr, input bit we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r0,
                         input logic [AW-1:0] r1, input string tag);
        Clear        = clr;
        WriteEnable  = we;
        WriteAddress = wa;
        WriteData    = wd;
        ReadAddress  = {r1, r0};
        @(negedge Clock);
        last_busy = busy0;
        check({tag, " busy"},     32'(busy0), 32'(busy_left > 0));
        check({tag, " busy_z"},   32'(busy1), 32'(busy_left > 0));
        check({tag, " dropped"},  32'(drop0), 32'(drop_exp));
        check({tag, " dropped_z"}, 32'(drop1), 32'(drop_exp));
        check({tag, " rd0 p0"},   32'(rd0[DW-1:0]),    32'(exp_rd(1'b0, r0)));
        check({tag, " rd0 p1"},   32'(rd0[2*DW-1:DW]), 32'(exp_rd(1'b0, r1)));
        check({tag, " rdz p0"},   32'(rd1[DW-1:0]),    32'(exp_rd(1'b1, r0)));
        check({tag, " rdz p1"},   32'(rd1[2*DW-1:DW]), 32'(exp_rd(1'b1, r1)));
        @(posedge Clock);
        if (busy_left > 0) begin
            busy_left--;
            drop_exp = we;
        end else if (clr) begin
            model_sweep_start();
            drop_exp = we;
        end else begin
            drop_exp = 1'b0;
            if (we) model[wa] = wd;
        end
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 1'b0, '0, '0, '0, '0, tag);
    endtask

    // Reset is asserted between edges and released one edge later.
    task automatic do_reset(input string tag);
        nReset = 1'b0;
        #2;
        model_sweep_start();
        drop_exp = 1'b0;
        check({tag, " async busy"},     32'(busy0), 32'd1);
        check({tag, " async busy_z"},   32'(busy1), 32'd1);
        check({tag, " async dropped"},  32'(drop0), 32'd0);
        check({tag, " async dropped_z"}, 32'(drop1), 32'd0);
        @(posedge Clock);
        #1;
        nReset = 1'b1;
    endtask

    // Idles until Busy falls (bounded) and checks how many busy cycles were seen.
    task automatic count_busy(input string tag, input int unsigned already, input int unsigned want);
        int unsigned n = already;
        for (int k = 0; k < 200; k++) begin
            idle(tag);
            if (last_busy) n++;
            else break;
        end
        check({tag, " busy length"}, n, want);
    endtask

    initial begin
        nReset = 1'b1; Clear = 1'b0; WriteEnable = 1'b0;
        WriteAddress = '0; WriteData = '0; ReadAddress = '0;
        busy_left = 0; drop_exp = 1'b0; last_busy = 1'b0;
        @(posedge Clock); #1;

        do_reset("reset");
        count_busy("reset sweep", 0, 64);
        for (int a = 0; a < DEPTH; a += 2)
            cycle(1'b0, 1'b0, '0, '0, AW'(a), AW'(a + 1), "post-reset read");

        cycle(1'b0, 1'b1, 6'd5, 16'hBEEF, 6'd0, 6'd5, "bypass beef");
        check("bypass beef direct", 32'(model[5]), 32'h0000_BEEF);
        cycle(1'b0, 1'b0, '0, '0, 6'd0, 6'd5, "stored beef");

        for (int k = 0; k < 300; k++) begin
            logic [AW-1:0] wa, r0, r1;
            wa = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            r0 = ($urandom_range(0, 1) != 0) ? wa : AW'($urandom_range(0, 7));
            r1 = AW'($urandom);
            cycle(($urandom_range(0, 119) == 0), 1'($urandom), wa, DW'($urandom), r0, r1, "random");
        end
        count_busy("drain", 0, busy_left);

        cycle(1'b1, 1'b1, 6'd3, 16'h1234, 6'd3, 6'd3, "clear+write");
        count_busy("clear collide", 0, 64);
        cycle(1'b0, 1'b0, '0, '0, 6'd3, 6'd4, "addr3 after clear");

        cycle(1'b0, 1'b1, 6'd7, 16'h5A5A, 6'd7, 6'd0, "prefill 7");
        cycle(1'b1, 1'b0, '0, '0, 6'd7, 6'd0, "start sweep");
        for (int k = 0; k < 10; k++) idle("sweep");
        cycle(1'b0, 1'b1, 6'd7, 16'hAAAA, 6'd7, 6'd7, "write in sweep");
        for (int k = 11; k < 20; k++) idle("sweep");
        cycle(1'b1, 1'b0, '0, '0, '0, '0, "clear in sweep");
        count_busy("clear ignored", 21, 64);
        cycle(1'b0, 1'b0, '0, '0, 6'd7, 6'd7, "addr7 after sweep");

        cycle(1'b0, 1'b1, 6'd0, 16'hFFFF, 6'd0, 6'd0, "zero-reg write");
        check("zero-reg dropped_z", 32'(drop1), 32'd0);
        cycle(1'b0, 1'b0, '0, '0, 6'd0, 6'd1, "zero-reg read");

        cycle(1'b1, 1'b0, '0, '0, '0, '0, "sweep before reset");
        for (int k = 0; k < 30; k++) idle("sweep");
        do_reset("mid-sweep reset");
        count_busy("restarted sweep", 0, 64);
        cycle(1'b0, 1'b0, '0, '0, 6'd5, 6'd0, "final read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_param_register_file
